// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator: combinational decode feeding a DEPTH-entry output FIFO.
// Optional IMM_GEN_CSR_EN macro enables CSR zimm (type Z) decoding for opcode 1110011.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst_code,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic [2:0]       imm_type,
  output logic             imm_err,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6,
    IMM_RSVD = 3'd7
  } imm_fmt_e;

  imm_fmt_e          dec_type;
  logic [31:0]       imm32;
  logic [XLEN-1:0]   dec_imm;
  logic              dec_err;

  logic [XLEN-1:0]   mem_imm  [DEPTH];
  logic [2:0]        mem_type [DEPTH];
  logic              mem_err  [DEPTH];
  logic [TAG_W-1:0]  mem_tag  [DEPTH];

  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW:0]       count;
  logic              push;
  logic              pop;

  // Every format is first built as a 32-bit value sign-extended from inst[31], then widened to XLEN.
  always_comb begin
    dec_type = IMM_NONE;
    imm32    = '0;
    dec_imm  = '0;
    dec_err  = (inst_code[1:0] != 2'b11);
    case (inst_code[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: begin
        dec_type = IMM_I;
        imm32    = {{20{inst_code[31]}}, inst_code[31:20]};
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          dec_type = IMM_I;
          imm32    = {{20{inst_code[31]}}, inst_code[31:20]};
        end
      end
      7'b0100011: begin
        dec_type = IMM_S;
        imm32    = {{20{inst_code[31]}}, inst_code[31:25], inst_code[11:7]};
      end
      7'b1100011: begin
        dec_type = IMM_B;
        imm32    = {{19{inst_code[31]}}, inst_code[31], inst_code[7],
                    inst_code[30:25], inst_code[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_type = IMM_U;
        imm32    = {inst_code[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_type = IMM_J;
        imm32    = {{11{inst_code[31]}}, inst_code[31], inst_code[19:12],
                    inst_code[20], inst_code[30:21], 1'b0};
      end
`ifdef IMM_GEN_CSR_EN
      7'b1110011: begin
        if (inst_code[14:12] inside {3'b101, 3'b110, 3'b111}) begin
          dec_type = IMM_Z;
        end
      end
`endif
      default: ;
    endcase
    if (dec_type == IMM_Z) begin
      dec_imm      = '0;
      dec_imm[4:0] = inst_code[19:15];
    end else begin
      dec_imm       = {XLEN{imm32[31]}};
      dec_imm[31:0] = imm32;
    end
  end

  assign in_ready  = (count < (PW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Storage is reset too so the outputs read as zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_imm[PW'(i)]  <= '0;
        mem_type[PW'(i)] <= '0;
        mem_err[PW'(i)]  <= 1'b0;
        mem_tag[PW'(i)]  <= '0;
      end
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        mem_imm[wr_ptr]  <= dec_imm;
        mem_type[wr_ptr] <= dec_type;
        mem_err[wr_ptr]  <= dec_err;
        mem_tag[wr_ptr]  <= in_tag;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign imm_out  = mem_imm[rd_ptr];
  assign imm_type = mem_type[rd_ptr];
  assign imm_err  = mem_err[rd_ptr];
  assign out_tag  = mem_tag[rd_ptr];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus,
// checked against a queue-based reference model plus directed constants.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] inst_code;
  logic [31:0] in_tag;

  logic        in_ready_a, out_valid_a, imm_err_a;
  logic [31:0] imm_out_a, out_tag_a;
  logic [2:0]  imm_type_a;
  logic        in_ready_b, out_valid_b, imm_err_b;
  logic [63:0] imm_out_b;
  logic [31:0] out_tag_b;
  logic [2:0]  imm_type_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(32)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .inst_code(inst_code), .in_tag(in_tag), .out_valid(out_valid_a), .out_ready(out_ready),
    .imm_out(imm_out_a), .imm_type(imm_type_a), .imm_err(imm_err_a), .out_tag(out_tag_a)
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(2), .TAG_W(32)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .inst_code(inst_code), .in_tag(in_tag), .out_valid(out_valid_b), .out_ready(out_ready),
    .imm_out(imm_out_b), .imm_type(imm_type_b), .imm_err(imm_err_b), .out_tag(out_tag_b)
  );

  typedef struct {
    logic [63:0] i32;
    logic [63:0] i64;
    logic [2:0]  t32;
    logic [2:0]  t64;
    logic        err;
    logic [31:0] tag;
  } ent_t;

  ent_t q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode from the ISA field layouts using signed arithmetic.
  function automatic void ref_dec(input logic [31:0] i, input bit x64,
                                  output logic [63:0] imm, output logic [2:0] ty);
    longint      v;
    logic [11:0] s12;
    logic [12:0] s13;
    logic [19:0] s20;
    logic [20:0] s21;
    v  = 0;
    ty = 3'd0;
    case (i[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: begin
        ty = 3'd1; s12 = i[31:20]; v = longint'($signed(s12));
      end
      7'b0011011: if (x64) begin
        ty = 3'd1; s12 = i[31:20]; v = longint'($signed(s12));
      end
      7'b0100011: begin
        ty = 3'd2; s12 = {i[31:25], i[11:7]}; v = longint'($signed(s12));
      end
      7'b1100011: begin
        ty = 3'd3; s13 = {i[31], i[7], i[30:25], i[11:8], 1'b0}; v = longint'($signed(s13));
      end
      7'b0110111, 7'b0010111: begin
        ty = 3'd4; s20 = i[31:12]; v = longint'($signed(s20)) * 4096;
      end
      7'b1101111: begin
        ty = 3'd5; s21 = {i[31], i[19:12], i[20], i[30:21], 1'b0}; v = longint'($signed(s21));
      end
`ifdef IMM_GEN_CSR_EN
      7'b1110011: if (i[14:12] >= 3'd5) begin
        ty = 3'd6; v = longint'(i[19:15]);
      end
`endif
      default: ;
    endcase
    imm = x64 ? 64'(v) : {32'b0, 32'(v)};
  endfunction

  task automatic check_outputs();
    chk("a_valid", {63'b0, out_valid_a}, {63'b0, q.size() != 0});
    chk("b_valid", {63'b0, out_valid_b}, {63'b0, q.size() != 0});
    chk("a_ready", {63'b0, in_ready_a},  {63'b0, q.size() < 2});
    chk("b_ready", {63'b0, in_ready_b},  {63'b0, q.size() < 2});
    if (q.size() != 0) begin
      chk("a_imm",  {32'b0, imm_out_a},  q[0].i32);
      chk("b_imm",  imm_out_b,           q[0].i64);
      chk("a_type", {61'b0, imm_type_a}, {61'b0, q[0].t32});
      chk("b_type", {61'b0, imm_type_b}, {61'b0, q[0].t64});
      chk("a_err",  {63'b0, imm_err_a},  {63'b0, q[0].err});
      chk("b_err",  {63'b0, imm_err_b},  {63'b0, q[0].err});
      chk("a_tag",  {32'b0, out_tag_a},  {32'b0, q[0].tag});
      chk("b_tag",  {32'b0, out_tag_b},  {32'b0, q[0].tag});
    end
  endtask

  // One clock: check at negedge, update the model at posedge, return 1 time unit later.
  task automatic step();
    bit   push;
    bit   pop;
    ent_t e;
    @(negedge clk);
    check_outputs();
    push = in_valid && (q.size() < 2);
    pop  = out_ready && (q.size() != 0);
    if (push) begin
      ref_dec(inst_code, 1'b0, e.i32, e.t32);
      ref_dec(inst_code, 1'b1, e.i64, e.t64);
      e.err = (inst_code[1:0] != 2'b11);
      e.tag = in_tag;
    end
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(e);
    end
    #1;
  endtask

  task automatic push_dir(input logic [31:0] inst, input logic [31:0] tag,
                          input logic [63:0] e32, input logic [2:0] t32,
                          input logic [63:0] e64, input logic [2:0] t64, input logic err);
    in_valid  = 1'b1;
    inst_code = inst;
    in_tag    = tag;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    chk("dir_a_valid", {63'b0, out_valid_a}, 64'd1);
    chk("dir_a_imm",   {32'b0, imm_out_a},   e32);
    chk("dir_a_type",  {61'b0, imm_type_a},  {61'b0, t32});
    chk("dir_b_imm",   imm_out_b,            e64);
    chk("dir_b_type",  {61'b0, imm_type_b},  {61'b0, t64});
    chk("dir_err",     {63'b0, imm_err_a},   {63'b0, err});
    chk("dir_tag",     {32'b0, out_tag_b},   {32'b0, tag});
  endtask

  logic [6:0] ops [10] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0011011, 7'b0100011,
                           7'b1100011, 7'b0110111, 7'b1101111, 7'b1110011, 7'b0000000};

  initial begin
    logic [31:0] r;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    inst_code = '0;
    in_tag    = '0;
    #2;
    chk("rst_a_valid", {63'b0, out_valid_a}, 64'd0);
    chk("rst_b_valid", {63'b0, out_valid_b}, 64'd0);
    chk("rst_a_ready", {63'b0, in_ready_a},  64'd1);
    chk("rst_a_imm",   {32'b0, imm_out_a},   64'd0);
    chk("rst_b_imm",   imm_out_b,            64'd0);
    chk("rst_a_type",  {61'b0, imm_type_a},  64'd0);
    chk("rst_a_err",   {63'b0, imm_err_a},   64'd0);
    chk("rst_a_tag",   {32'b0, out_tag_a},   64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    push_dir(32'hFFF00093, 32'h100, 64'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
    push_dir(32'hFE112E23, 32'h104, 64'hFFFFFFFC, 3'd2, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0);
    push_dir(32'hFE000CE3, 32'h108, 64'hFFFFFFF8, 3'd3, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0);
    push_dir(32'h123450B7, 32'h10C, 64'h12345000, 3'd4, 64'h0000000012345000, 3'd4, 1'b0);
    push_dir(32'h001000EF, 32'h110, 64'h00000800, 3'd5, 64'h0000000000000800, 3'd5, 1'b0);
    push_dir(32'h800000B7, 32'h114, 64'h80000000, 3'd4, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
    push_dir(32'h0010009B, 32'h118, 64'h0,        3'd0, 64'h1,                3'd1, 1'b0);
    push_dir(32'h00000000, 32'h11C, 64'h0,        3'd0, 64'h0,                3'd0, 1'b1);
`ifdef IMM_GEN_CSR_EN
    push_dir(32'h3402D073, 32'h120, 64'h5,        3'd6, 64'h5,                3'd6, 1'b0);
`else
    push_dir(32'h3402D073, 32'h120, 64'h0,        3'd0, 64'h0,                3'd0, 1'b0);
`endif
    step();

    // Backpressure: two entries fill the FIFO, the third is refused.
    out_ready = 1'b0;
    inst_code = 32'h00100093;
    in_valid  = 1'b1;
    in_tag    = 32'd1; step();
    in_tag    = 32'd2; step();
    chk("full_ready", {63'b0, in_ready_a}, 64'd0);
    in_tag    = 32'd3; step();
    in_valid  = 1'b0;
    step();
    chk("stall_tag", {32'b0, out_tag_a}, 64'd1);
    out_ready = 1'b1;
    step();
    chk("pop_tag2", {32'b0, out_tag_a}, 64'd2);
    chk("pop_ready", {63'b0, in_ready_a}, 64'd1);
    step();
    chk("drained", {63'b0, out_valid_a}, 64'd0);
    in_valid  = 1'b1;
    in_tag    = 32'd3; step();
    in_valid  = 1'b0;
    chk("late_tag3", {32'b0, out_tag_b}, 64'd3);
    step();

    // Flush beats a simultaneous push.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_tag    = 32'h10; step();
    flush     = 1'b1;
    in_tag    = 32'h11; step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    chk("flush_valid", {63'b0, out_valid_a}, 64'd0);
    chk("flush_ready", {63'b0, in_ready_b},  64'd1);
    step();

    // Asynchronous reset mid-stream.
    in_valid  = 1'b1;
    in_tag    = 32'h20; step();
    in_valid  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_a_valid", {63'b0, out_valid_a}, 64'd0);
    chk("arst_b_valid", {63'b0, out_valid_b}, 64'd0);
    chk("arst_ready",   {63'b0, in_ready_a},  64'd1);
    q.delete();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomised traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      r         = $urandom();
      inst_code = ($urandom_range(7) == 0) ? r : {r[31:7], ops[$urandom_range(9)]};
      in_tag    = $urandom();
      in_valid  = $urandom_range(3) != 0;
      out_ready = $urandom_range(2) != 0;
      flush     = $urandom_range(31) == 0;
      step();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
